fxp_divider: RTL and testbench
==============================

Name: fxp_divider

Overview:
- Sequential signed two's-complement fixed-point divider, one quotient bit per clock (restoring, on magnitudes).
- Used by datapath blocks for Q-format division.
- Operands load while reset is held. Releasing reset starts the divide. `complete` flags a valid quotient or a divide-by-zero.

Parameters:
- DATA_WIDTH, 32: total width of operands and quotient.
- BIN_POS, 16: number of fractional bits (binary point position). Constraint: 0 <= BIN_POS < DATA_WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset; also the operand-load/start control.
- ready  output  1  block is reset and operands are captured; safe to release rst.
- complete  output  1  result valid (quot or div_zero); held until rst.
- num  input  DATA_WIDTH  signed fixed-point dividend.
- denom  input  DATA_WIDTH  signed fixed-point divisor.
- quot  output  DATA_WIDTH  signed fixed-point quotient.
- div_zero  output  1  denom was zero.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset / load:
  - Every rising edge with rst=1 captures num and denom into internal registers.
  - On those edges: complete=0, div_zero=0, quot=0, ready=1.
  - ready therefore reads 1 from the first edge with rst=1 onward.
  - Operands are sampled only while rst=1; changes to num/denom while rst=0 are ignored.
- Start:
  - First edge with rst=0 after a load: ready<=0.
  - If captured denom==0: complete<=1, div_zero<=1, quot<=0 on that same edge (latency 1).
  - Otherwise the FSM enters DIVIDE.
- States:
  - IDLE/LOADED: rst=1.
  - DIVIDE: iterate.
  - DONE: hold outputs.
- Arithmetic:
  - Signs are taken from the MSB of the captured operands.
  - Magnitudes are DATA_WIDTH-bit unsigned; abs(most-negative) = 2^(DATA_WIDTH-1) is legal.
  - Dividend magnitude is extended to DATA_WIDTH+BIN_POS bits and shifted left by BIN_POS.
  - Restoring divide runs DATA_WIDTH+BIN_POS iterations, one per clock. It yields the integer quotient Q = floor(|num|*2^BIN_POS / |denom|).
  - Result is truncated toward zero.
  - Result is negated if the signs differ and Q != 0.
  - quot = low DATA_WIDTH bits of the signed result (see Optional Feature).
- Latency:
  - complete rises on the (DATA_WIDTH+BIN_POS+1)th edge with rst=0 after the load. Example: 49 edges at defaults.
  - quot and div_zero are valid on the same edge.
- DONE:
  - complete, quot and div_zero stay constant until an edge with rst=1.
  - Further edges with rst=0 have no effect.
- Reset mid-operation: rst=1 on any edge aborts the divide, discards partial state and reloads operands. complete=0 and ready=1 after that edge.
- rst held high for many cycles: ready stays 1 and operands are re-captured every edge (last value wins).
- No other outputs change while idle.

Optional Feature:
- Macro: FXP_DIV_SATURATE_EN.
- Defined: if the signed result does not fit in DATA_WIDTH bits, quot saturates.
  - Positive overflow: 0111..1.
  - Negative overflow: 1000..0.
  - div_zero is unaffected.
- Undefined: quot is the low DATA_WIDTH bits of the two's-complement result (wraps).
- Latency is identical in both builds.

Test Plan (DATA_WIDTH=32, BIN_POS=16):
- Load num=0x00060000 (6.0), denom=0x00020000 (2.0), release rst -> after 49 edges complete=1, quot=0x00030000, div_zero=0.
- num=0xFFFD0000 (-3.0), denom=0x00020000 (2.0) -> quot=0xFFFE8000 (-1.5). Also with num=0x00030000, denom=0xFFFE0000 (-2.0) -> quot=0xFFFE8000.
- num=0x00010000, denom=0x00030000 -> quot=0x00005555 (truncated 1/3). num=0xFFFF0000, denom=0x00030000 -> quot=0xFFFFAAAB (-0x5555).
- denom=0x00000000, num=0x00050000 -> complete=1 on first edge after rst release, div_zero=1, quot=0.
- num=0x7FFF0000, denom=0x00000001:
  - With FXP_DIV_SATURATE_EN -> quot=0x7FFFFFFF.
  - Without -> quot=0x00000000.
- Reset abort and back-to-back runs:
  - Assert rst 10 edges into a divide -> complete stays 0 and ready=1 next edge.
  - Reload 6.0/2.0 and release -> correct 0x00030000.
  - Repeat 1000 random operands (integer part -9..9, random fraction) against a software model.

Source files
------------

// File: rtl/fxp_divider.sv
// fxp_divider: sequential signed fixed-point divider, one quotient bit per clock.
// Restoring division on operand magnitudes; sign is applied to the final quotient.
// Operands are captured on every clock edge while rst is high; the first edge
// with rst low starts the divide.
// Optional build macro: FXP_DIV_SATURATE_EN (saturate quot on overflow instead
// of wrapping).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | rst held: operands captured every edge, outputs cleared
//   S_DIVIDE | one restoring-division step per edge
//   S_DONE   | result (or divide-by-zero) held until the next rst
module fxp_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int BIN_POS    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  output logic                  complete,
  input  logic [DATA_WIDTH-1:0] num,
  input  logic [DATA_WIDTH-1:0] denom,
  output logic [DATA_WIDTH-1:0] quot,
  output logic                  div_zero
);

  localparam int N  = DATA_WIDTH + BIN_POS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_num;
  logic [DATA_WIDTH-1:0] r_den;
  logic [DATA_WIDTH-1:0] r_den_mag;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [N-1:0]          r_dvd;
  logic [CW-1:0]         r_cnt;
  logic                  r_neg;
  logic                  r_ready;
  logic                  r_complete;
  logic                  r_div_zero;
  logic [DATA_WIDTH-1:0] r_quot;

  logic [DATA_WIDTH-1:0] w_num_mag;
  logic [DATA_WIDTH-1:0] w_den_mag;
  logic [N-1:0]          w_num_ext;
  logic [DATA_WIDTH:0]   w_rem_sh;
  logic                  w_ge;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [N-1:0]          w_dvd_next;
  logic [DATA_WIDTH-1:0] w_q_lo;
  logic [DATA_WIDTH-1:0] w_wrap;
  logic [DATA_WIDTH-1:0] w_quot;

  // Magnitudes of the captured operands; most-negative maps to 2^(DATA_WIDTH-1).
  always_comb begin
    w_num_mag = r_num[DATA_WIDTH-1] ? (~r_num + 1'b1) : r_num;
    w_den_mag = r_den[DATA_WIDTH-1] ? (~r_den + 1'b1) : r_den;
    w_num_ext = N'(w_num_mag) << BIN_POS;
  end

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor when it fits, and shift the quotient bit into r_dvd.
  always_comb begin
    w_rem_sh   = {r_rem, r_dvd[N-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_den_mag});
    w_rem_next = w_ge ? (w_rem_sh[DATA_WIDTH-1:0] - r_den_mag) : w_rem_sh[DATA_WIDTH-1:0];
    w_dvd_next = {r_dvd[N-2:0], w_ge};
  end

  // Final quotient: sign applied, then wrapped or saturated to DATA_WIDTH bits.
  always_comb begin
    w_q_lo = w_dvd_next[DATA_WIDTH-1:0];
    w_wrap = r_neg ? (~w_q_lo + 1'b1) : w_q_lo;
`ifdef FXP_DIV_SATURATE_EN
    if (!r_neg && (w_dvd_next > ((N'(1) << (DATA_WIDTH-1)) - N'(1)))) begin
      w_quot = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (r_neg && (w_dvd_next > (N'(1) << (DATA_WIDTH-1)))) begin
      w_quot = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      w_quot = w_wrap;
    end
`else
    w_quot = w_wrap;
`endif
  end

  // Control FSM and datapath registers; rst doubles as operand load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_num      <= num;
      r_den      <= denom;
      r_ready    <= 1'b1;
      r_complete <= 1'b0;
      r_div_zero <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_den_mag  <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (r_den == '0) begin
            r_complete <= 1'b1;
            r_div_zero <= 1'b1;
            r_quot     <= '0;
            r_state    <= S_DONE;
          end else begin
            r_rem     <= '0;
            r_dvd     <= w_num_ext;
            r_den_mag <= w_den_mag;
            r_neg     <= r_num[DATA_WIDTH-1] ^ r_den[DATA_WIDTH-1];
            r_cnt     <= CW'(N-1);
            r_state   <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_dvd <= w_dvd_next;
          if (r_cnt == '0) begin
            r_quot     <= w_quot;
            r_complete <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign complete = r_complete;
  assign quot     = r_quot;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_fxp_divider.sv
// tb_fxp_divider: directed vectors, hand-written reset/abort sequences and
// randomized operands checked against an arithmetic reference model.
module tb_fxp_divider;

  localparam int DW = 32;
  localparam int BP = 16;
  localparam int LAT = DW + BP + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready;
  logic          complete;
  logic [DW-1:0] num = '0;
  logic [DW-1:0] denom = '0;
  logic [DW-1:0] quot;
  logic          div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  fxp_divider #(.DATA_WIDTH(DW), .BIN_POS(BP)) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .complete (complete),
    .num      (num),
    .denom    (denom),
    .quot     (quot),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] n;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic          dz;
    int            lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: Q = floor(|n|*2^BP/|d|), signed, then wrap or saturate to DW bits.
  function automatic logic [DW-1:0] model_q(input logic [DW-1:0] n, input logic [DW-1:0] d);
    longint sn, sd, mn, md, q, r;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    mn = (sn < 0) ? -sn : sn;
    md = (sd < 0) ? -sd : sd;
    q  = (mn * 65536) / md;
    r  = ((sn < 0) != (sd < 0)) ? -q : q;
`ifdef FXP_DIV_SATURATE_EN
    if (r > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (r < -64'sh80000000) return 32'h80000000;
`endif
    return r[DW-1:0];
  endfunction

  // Hold rst high for `edges` edges with the given operands.
  task automatic load(input logic [DW-1:0] n, input logic [DW-1:0] d, input int edges);
    @(negedge clk);
    rst = 1'b1; num = n; denom = d;
    repeat (edges) @(negedge clk);
  endtask

  // Release rst (called at a negedge) and wait for complete, scrambling inputs.
  task automatic run(output logic [DW-1:0] q, output logic dz, output int lat,
                     output logic rdy1);
    rst = 1'b0; lat = 0; rdy1 = 1'b1;
    num = $urandom; denom = $urandom;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) rdy1 = ready;
      if (complete) break;
    end
    q = quot; dz = div_zero;
  endtask

  vec_t vecs[9];

  initial begin
    logic [DW-1:0] q, q0;
    logic          dz, rdy1, seen;
    int            lat;

    vecs[0] = '{32'h00060000, 32'h00020000, 32'h00030000, 1'b0, LAT};
    vecs[1] = '{32'hFFFD0000, 32'h00020000, 32'hFFFE8000, 1'b0, LAT};
    vecs[2] = '{32'h00030000, 32'hFFFE0000, 32'hFFFE8000, 1'b0, LAT};
    vecs[3] = '{32'h00010000, 32'h00030000, 32'h00005555, 1'b0, LAT};
    vecs[4] = '{32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 1'b0, LAT};
    vecs[5] = '{32'h00050000, 32'h00000000, 32'h00000000, 1'b1, 1};
`ifdef FXP_DIV_SATURATE_EN
    vecs[6] = '{32'h7FFF0000, 32'h00000001, 32'h7FFFFFFF, 1'b0, LAT};
    vecs[7] = '{32'h80000000, 32'hFFFF0000, 32'h7FFFFFFF, 1'b0, LAT};
`else
    vecs[6] = '{32'h7FFF0000, 32'h00000001, 32'h00000000, 1'b0, LAT};
    vecs[7] = '{32'h80000000, 32'hFFFF0000, 32'h80000000, 1'b0, LAT};
`endif
    vecs[8] = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, LAT};

    // Reset state after a load.
    load(32'h00060000, 32'h00020000, 2);
    check("reset_ready", ready, 1);
    check("reset_complete", complete, 0);
    check("reset_quot", quot, 0);
    check("reset_div_zero", div_zero, 0);

    // Directed vectors.
    foreach (vecs[i]) begin
      load(vecs[i].n, vecs[i].d, 2);
      run(q, dz, lat, rdy1);
      check($sformatf("vec%0d_ready_drop", i), rdy1, (vecs[i].lat == 1) ? 0 : 0);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_quot", i), q, vecs[i].q);
      check($sformatf("vec%0d_div_zero", i), dz, vecs[i].dz);
    end

    // DONE holds outputs while rst stays low.
    load(32'h00010000, 32'h00030000, 1);
    run(q0, dz, lat, rdy1);
    repeat (7) @(posedge clk);
    #1;
    check("done_hold_complete", complete, 1);
    check("done_hold_quot", quot, 32'h00005555);
    check("done_hold_ready", ready, 0);

    // Abort 10 edges into a divide.
    load(32'h00060000, 32'h00020000, 1);
    rst = 1'b0; seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (complete) seen = 1'b1;
    end
    check("abort_no_early_complete", seen, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_complete", complete, 0);
    check("abort_ready", ready, 1);

    // rst held several edges with changing operands: last value wins.
    @(negedge clk); num = 32'h12345678; denom = 32'h00000000;
    @(negedge clk); num = 32'hFFFD0000; denom = 32'h00070000;
    @(negedge clk); num = 32'h00060000; denom = 32'h00020000;
    @(negedge clk);
    run(q, dz, lat, rdy1);
    check("reload_latency", lat, LAT);
    check("reload_quot", q, 32'h00030000);
    check("reload_div_zero", dz, 0);

    // Randomized operands: integer part -9..9 with random fraction.
    for (int k = 0; k < 1000; k++) begin
      logic [DW-1:0] rn, rd, eq;
      logic          edz;
      int            ip;
      ip = int'($urandom_range(18)) - 9;
      rn = (DW'(ip) << 16) | DW'($urandom_range(65535));
      ip = int'($urandom_range(18)) - 9;
      rd = (DW'(ip) << 16) | DW'($urandom_range(65535));
      if ($urandom_range(49) == 0) rd = '0;
      edz = (rd == '0);
      eq  = edz ? '0 : model_q(rn, rd);
      load(rn, rd, 1);
      run(q, dz, lat, rdy1);
      check($sformatf("rand%0d_quot n=%0h d=%0h", k, rn, rd), q, eq);
      check($sformatf("rand%0d_div_zero", k), dz, edz);
      check($sformatf("rand%0d_latency", k), lat, edz ? 1 : LAT);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
